// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial_rx UART receiver (8N1, LSB first).
// clock_frequency mirrors the board clock shared by the FPGA I/O test build.
// Optional feature macro: RX_MAJORITY_EN (2-of-3 majority sampling).
package serial_rx_pkg;

    // System clock feeding clk100, in Hz.
    localparam int clock_frequency = 100_000_000;

    // Receiver sequencing states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    // 2-of-3 vote used to reject single-clock glitches on the line.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Line front end for serial_rx: two-flop synchroniser on the asynchronous
// rx pin, plus a short history for majority voting when RX_MAJORITY_EN is
// defined. rx_s is the plain synchronised line (used for edge detection);
// rx_bit is the value the state machine takes at its sample points.
module rx_sync
    import serial_rx_pkg::*;
(
    input  logic clk100,
    input  logic reset,
    input  logic rx,
    input  logic sample,
    output logic rx_s,
    output logic rx_bit
);

    logic meta;

    // Two-flop synchroniser; both stages idle high so reset looks like a quiet line.
    always_ff @(posedge clk100) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

`ifdef RX_MAJORITY_EN
    logic [1:0] hist;

    // Two previous rx_s values; with the current one they form the vote window.
    always_ff @(posedge clk100) begin
        if (reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    // The state machine samples one clock late in this build, so the window
    // is centred on the nominal sample point.
    assign rx_bit = maj3(rx_s, hist[0], hist[1]);
`else
    assign rx_bit = rx_s;
`endif

    // The vote is combinational, so the sample strobe is only informative here.
    logic unused_sample;
    assign unused_sample = sample;

endmodule

// File: rtl/serial_rx.sv
// UART receiver, 8N1, LSB first, fixed baud rate. Deserialises into a
// one-character holding register with sticky ready/overrun/framing flags,
// all cleared by a single-cycle rx_ack.
// Optional feature macro: RX_MAJORITY_EN (2-of-3 majority sampling, sample
// points move one clock later).
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int baud_rate = 9600
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_char,
    output logic       rx_ready,
    output logic       overrun,
    output logic       framing_err
);

    localparam int term_count = clock_frequency / baud_rate;
    localparam int half_count = term_count / 2;
    localparam int CNT_W      = $clog2(term_count);

`ifdef RX_MAJORITY_EN
    localparam int SAMPLE_SHIFT = 1;
`else
    localparam int SAMPLE_SHIFT = 0;
`endif

    // The counter is acted on when it reads 0, so loads are one less than
    // the distance to the next sample point.
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(half_count - 1 + SAMPLE_SHIFT);
    localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(term_count - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       char_n;
    logic             ready_n, ovr_n, ferr_n;
    logic             rx_s, rx_bit;
    logic             sample;

    assign sample = (cnt == '0) &&
                    (state == S_START || state == S_DATA || state == S_STOP);

    rx_sync u_sync (
        .clk100 (clk100),
        .reset  (reset),
        .rx     (rx),
        .sample (sample),
        .rx_s   (rx_s),
        .rx_bit (rx_bit)
    );

    // State, counter, shift register and flags.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            rx_char     <= '0;
            rx_ready    <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            rx_char     <= char_n;
            rx_ready    <= ready_n;
            overrun     <= ovr_n;
            framing_err <= ferr_n;
        end
    end

    // Next-state and datapath decisions; flag sets below override the ack clear.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        char_n  = rx_char;
        ready_n = rx_ready;
        ovr_n   = overrun;
        ferr_n  = framing_err;

        if (rx_ack) begin
            ready_n = 1'b0;
            ovr_n   = 1'b0;
            ferr_n  = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = START_LOAD;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!rx_bit) begin
                        cnt_n   = BIT_LOAD;
                        idx_n   = '0;
                        state_n = S_DATA;
                    end else begin
                        // Too short to be a start bit: treat as noise.
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shreg_n = {rx_bit, shreg[7:1]};
                    cnt_n   = BIT_LOAD;
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    if (rx_bit) begin
                        char_n  = shreg;
                        ready_n = 1'b1;
                        // An ack in this same cycle consumes the old character.
                        if (rx_ready && !rx_ack) begin
                            ovr_n = 1'b1;
                        end
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a break is not
                // seen as a stream of start bits.
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx. Runs the receiver at 20 clocks per bit
// (baud_rate overridden to 5 Mbit/s on the 100 MHz clock) with a table of
// frame/ack steps plus hand-written sequences for latency, glitch,
// ack-at-stop, mid-frame reset and +/-3 % loopback.
module tb_serial_rx;
    import serial_rx_pkg::*;

    localparam int BAUD = 5_000_000;
    localparam int TERM = 20;
    localparam int NOM  = TERM * 100;

    logic       clk100 = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_char;
    logic       rx_ready;
    logic       overrun;
    logic       framing_err;

    int n_cmp = 0;
    int n_bad = 0;

    serial_rx #(.baud_rate(BAUD)) dut (
        .clk100      (clk100),
        .reset       (reset),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_char     (rx_char),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .framing_err (framing_err)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        bit         is_ack;
        bit         bad_stop;
        logic [7:0] data;
        logic [7:0] e_char;
        bit         e_rdy;
        bit         e_ovr;
        bit         e_ferr;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk100);
    endtask

    // Drive nbits LSB first; bit edges at round(k*per100/100) clocks.
    task automatic send_bits(input logic [15:0] bits, input int nbits, input int per100);
        int t;
        int target;
        t = 0;
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            target = ((i + 1) * per100 + 50) / 100;
            repeat (target - t) @(negedge clk100);
            t = target;
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input int per100);
        send_bits({6'h3F, 1'b1, c, 1'b0}, 10, per100);
    endtask

    // Stop bit held low for two bit times.
    task automatic send_bad_frame(input logic [7:0] c);
        send_bits({5'h1F, 2'b00, c, 1'b0}, 11, NOM);
    endtask

    task automatic pulse_ack;
        rx_ack = 1'b1;
        @(negedge clk100);
        rx_ack = 1'b0;
        @(negedge clk100);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input bit r, input bit o, input bit f);
        chk({tag, " rx_char"},     32'(rx_char),     32'(c));
        chk({tag, " rx_ready"},    32'(rx_ready),    32'(r));
        chk({tag, " overrun"},     32'(overrun),     32'(o));
        chk({tag, " framing_err"}, 32'(framing_err), 32'(f));
    endtask

    initial begin
        int lat;

        vt[0]  = '{1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 8'h20, 8'h20, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 8'h21, 8'h21, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 8'h00, 8'h21, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 8'h7E, 8'h21, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 8'h0D, 8'h0D, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 8'h00, 8'h0D, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0};

        reset  = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        idle(3);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset state", 32'(dut.state), 32'(S_IDLE));
        reset = 1'b0;
        idle(5);

        // 'A' with a bounded wait for rx_ready measured from the start edge.
        lat = 0;
        fork
            send_frame(8'h41, NOM);
            begin
                while (!rx_ready && lat < 250) begin
                    @(negedge clk100);
                    lat++;
                end
            end
        join
        chk($sformatf("ready latency %0d clocks within 185..203", lat),
            32'(lat >= 185 && lat <= 10 * TERM + 3), 32'd1);
        idle(5);
        chk_all("frame 41", 8'h41, 1'b1, 1'b0, 1'b0);

        // Start pulse shorter than half a bit must be ignored.
        send_bits(16'hFFFE, 1, (TERM / 2 - 2) * 100);
        idle(60);
        chk_all("glitch", 8'h41, 1'b1, 1'b0, 1'b0);
        chk("glitch state", 32'(dut.state), 32'(S_IDLE));
        pulse_ack();
        send_frame(8'h55, NOM);
        idle(5);
        chk_all("frame 55", 8'h55, 1'b1, 1'b0, 1'b0);

        foreach (vt[i]) begin
            if (vt[i].is_ack) begin
                pulse_ack();
            end else if (vt[i].bad_stop) begin
                send_bad_frame(vt[i].data);
                idle(TERM);
            end else begin
                send_frame(vt[i].data, NOM);
                idle(5);
            end
            chk_all($sformatf("row%0d", i), vt[i].e_char, vt[i].e_rdy, vt[i].e_ovr, vt[i].e_ferr);
        end

        // rx_ack lands on the stop sample of 0x0A while rx_ready is already set.
        fork
            send_frame(8'h0A, NOM);
            begin
                idle(192);
                rx_ack = 1'b1;
                @(negedge clk100);
                rx_ack = 1'b0;
            end
        join
        idle(5);
        chk_all("ack at stop", 8'h0A, 1'b1, 1'b0, 1'b0);

        // Reset during bit 4 of 0x33; outputs must read reset values.
        fork
            send_frame(8'h33, NOM);
            begin
                idle(90);
                reset = 1'b1;
                idle(2);
                chk_all("mid-frame reset", 8'h00, 1'b0, 1'b0, 1'b0);
                reset = 1'b0;
            end
        join
        idle(11 * TERM);
        pulse_ack();
        send_frame(8'h34, NOM);
        idle(5);
        chk("after reset rx_char", 32'(rx_char), 32'h34);
        chk("after reset rx_ready", 32'(rx_ready), 32'd1);
        chk("after reset overrun", 32'(overrun), 32'd0);

        // Back-to-back loopback at -3 % and +3 % bit period.
        for (int s = 0; s < 2; s++) begin
            int per;
            per = (s == 0) ? (NOM * 97) / 100 : (NOM * 103) / 100;
            idle(2 * TERM);
            pulse_ack();
            for (int c = 8'h20; c <= 8'h7E; c++) begin
                send_frame(8'(c), per);
                chk($sformatf("loop per%0d char %0h", per, c), 32'(rx_char), 32'(c));
            end
            chk($sformatf("loop per%0d framing_err", per), 32'(framing_err), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

UART receiver for the FPGA I/O test build: 8N1, LSB first, at a fixed baud rate derived from the shared `clock_frequency`. It deserialises the console line into a one-character holding register and raises a sticky ready flag, in the style of the KL8E keyboard flag. It is the receive-side companion of the test transmitter, so its character stream can be looped back and checked.

## Interface
- `baud_rate`, 9600: line rate in bits/s.
- `clock_frequency` is not a parameter. It comes from `HX_clock.v`.
- `term_count`: localparam, `$rtoi(clock_frequency / baud_rate)`. This is the number of clocks per bit.
- `half_count`: localparam, `term_count / 2`.
- `clk100` in 1: system clock. Every register updates on its rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input. The idle level is 1.
- `rx_ack` in 1: single-cycle strobe. It clears `rx_ready`, `overrun` and `framing_err`.
- `rx_char` out 8: last good character received. Bit 0 is the first data bit.
- `rx_ready` out 1: sticky; a new character is in `rx_char`.
- `overrun` out 1: sticky; a character completed while `rx_ready` was already 1.
- `framing_err` out 1: sticky; the stop bit was sampled as 0.

## Operation
- Input synchroniser: two flops. Both reset to 1. Call the synchronised signal `rx_s`.
- State machine: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When `rx_s` is 0, load the counter with `half_count` and go to START.
- START, when the counter reaches 0:
  - If `rx_s` is 0, this is a valid start bit. Load `term_count`, clear the bit index, go to DATA.
  - If `rx_s` is 1, this is a glitch. Return to IDLE; no flags change.
- DATA, each time the counter reaches 0:
  - Shift `rx_s` into the MSB of the shift register (right shift) and reload `term_count`.
  - After bit index 7, go to STOP.
- STOP, when the counter reaches 0:
  - If `rx_s` is 1: load `rx_char` from the shift register and set `rx_ready`. If `rx_ready` was already 1 and `rx_ack` is not asserted, also set `overrun`; the new character overwrites the old one. Go to IDLE.
  - If `rx_s` is 0: set `framing_err` and discard the character (`rx_char` and `rx_ready` are unchanged). Go to BREAK.
- BREAK:
  - Wait for `rx_s` to be 1, then go to IDLE. This blocks false starts during a line break.
- `rx_ack` clears all three flags in the cycle it is sampled. Exception: if `rx_ack` and a good stop bit occur in the same cycle, `rx_ready` is 1 afterwards and `overrun` is 0.
- The counter is `$clog2(term_count)` bits wide and counts down. No arithmetic wraps, because every path reloads the counter before it underflows.

## Timing
- Reset values:
  - `rx_char` = 0, `rx_ready` = 0, `overrun` = 0, `framing_err` = 0.
  - State = IDLE, counter = 0, synchroniser = 11.
- Reset in the middle of a frame aborts it. The remainder of the frame is treated as line noise: a 0 data bit after reset is taken as a new start bit. A framing error on that frame is acceptable.
- Sample points, relative to the first synchronised low of the start bit:
  - Start bit sampled at `half_count`.
  - Data bit n sampled at `half_count + (n+1)*term_count`.
  - Stop bit sampled at `half_count + 9*term_count`.
- Input latency: 2 clocks from a pin edge to `rx_s`.
- `rx_ready` rises in the clock after the stop sample. That is about 9.5 bit times plus 3 clocks after the start edge.
- Earliest restart: a new start bit is accepted from the cycle after leaving STOP. This allows back-to-back frames with a stop bit of 0.5 bit time or longer.
- Tolerated baud mismatch: ±4 %.

## Configuration
- `RX_MAJORITY_EN` defined:
  - Each sample is the 2-of-3 majority of `rx_s` at counter values 1, 0 and the previous `term_count − 1`. In practice it uses a 3-bit history of `rx_s` taken at the sample point.
  - Sample points shift by one clock.
  - Single-clock glitches are rejected, including during start validation.
- `RX_MAJORITY_EN` undefined: each sample is the single value of `rx_s` at counter 0.

## Structure
- Shared constants in the `HX_clock.v` include: `clock_frequency` only.
- Module-local constants: the state encoding and `term_count`/`half_count`, as localparams.
- One sub-module, `rx_sync`:
  - The two-flop synchroniser, plus the majority history when `RX_MAJORITY_EN` is defined.
  - Ports: `clk100`, `reset`, `rx`, `sample`, `rx_s`, `rx_bit`.
  - The state machine, counter, shift register and flags stay in `serial_rx`.

## Test plan
- Frame 0x41 ('A') at exactly `term_count` per bit -> `rx_char` = 0x41, `rx_ready` = 1, `overrun` = 0 and `framing_err` = 0 within `10*term_count` + 3 clocks.
- Start pulse of `half_count` − 2 clocks followed by idle -> no flag changes; state is back in IDLE. Then frame 0x55 -> `rx_char` = 0x55.
- Frames 0x20 then 0x21 with no `rx_ack` -> `rx_char` = 0x21, `rx_ready` = 1, `overrun` = 1. Then `rx_ack` -> all three flags are 0 and `rx_char` stays 0x21.
- Frame 0x7E with the stop bit held at 0 for 2 bit times -> `framing_err` = 1, `rx_char` and `rx_ready` unchanged, no spurious character. Then line idle and frame 0x0D -> `rx_char` = 0x0D.
- `rx_ack` pulsed in the same clock as the stop sample of 0x0A, with `rx_ready` already 1 -> `rx_ready` = 1, `overrun` = 0, `rx_char` = 0x0A.
- `reset` asserted at bit 4 of frame 0x33, then a full frame 0x34 -> all outputs at their reset values during reset, then `rx_char` = 0x34 and `rx_ready` = 1. Repeat at ±3 % bit period with the transmitter looped back over 0x20..0x7E -> every character matches.
